bus_cmd_issuer: RTL and testbench
=================================

# bus_cmd_issuer

Upstream master-side driver for the dual-bus system: accepts bus commands (address, write data, read/write) through a valid/ready port, buffers them in a small FIFO, and issues them one at a time on the dual-bus master port (maddr/mwdata/wen/mwvalid/mready). It tracks each transfer to completion and returns a one-cycle response carrying read data and a timeout flag. It replaces hand-driven stimulus as the producer of master transactions.

## Interface
- ADDR_WIDTH, 16, bus address width
- DATA_WIDTH, 8, bus data width
- FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- TIMEOUT, 255, max cycles spent waiting on mready per transfer (≥8)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (= not full)
- cmd_addr  in  ADDR_WIDTH  command address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- cmd_wen  in  1  1 = write, 0 = read
- maddr  out  ADDR_WIDTH  bus address
- mwdata  out  DATA_WIDTH  bus write data
- wen  out  1  bus write enable
- mwvalid  out  1  one-cycle transfer-start pulse
- mready  in  1  bus idle/done (high = idle)
- mrdata  in  DATA_WIDTH  read data, valid when mready returns high after a read
- rsp_valid  out  1  one-cycle completion pulse, no backpressure
- rsp_rdata  out  DATA_WIDTH  captured read data (0 for writes/timeouts)
- rsp_wen  out  1  wen of the completed command
- rsp_timeout  out  1  transfer abandoned by timeout
- busy  out  1  FIFO non-empty or transfer in flight

## Operation
- FIFO: push on cmd_valid && cmd_ready; entry = {addr, wdata, wen}. Pointers wrap modulo FIFO_DEPTH; full/empty via count (width clog2(FIFO_DEPTH)+1).
- FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, RESP.
- IDLE: if FIFO non-empty and mready=1 → pop head into output registers (maddr, wen, mwdata = wdata if write else 0), go ISSUE. mready=0 in IDLE: stall, no issue.
- ISSUE: mwvalid=1 for exactly this state (one cycle); clear timeout counter; → WAIT_LOW.
- WAIT_LOW: mready=0 → WAIT_HIGH. Counter increments each cycle.
- WAIT_HIGH: mready=1 → capture mrdata (if read), → RESP.
- Timeout: in WAIT_LOW/WAIT_HIGH, counter reaching TIMEOUT → RESP with timeout flag set, rdata=0.
- RESP: rsp_valid=1 one cycle with rsp_wen, rsp_rdata, rsp_timeout; → IDLE.
- maddr/mwdata/wen held stable from ISSUE through RESP; retain last values in IDLE.
- Push while popping in same cycle allowed; count unchanged. Push when full impossible (cmd_ready=0).
- busy = (count≠0) || state≠IDLE.

## Timing
- Reset (rst sampled high at edge): state=IDLE, FIFO flushed (count=0, pointers 0), cmd_ready=1, maddr=0, mwdata=0, wen=0, mwvalid=0, rsp_valid=0, rsp_rdata=0, rsp_wen=0, rsp_timeout=0, busy=0, counter=0.
- Reset mid-transfer: in-flight transfer and queued commands dropped; no rsp_valid emitted.
- Latency: command accepted at edge E into empty FIFO with FSM IDLE and mready=1 → ISSUE (mwvalid high) in cycle after edge E+1.
- Completion: mready observed high in WAIT_HIGH at edge F → rsp_valid high in cycle after edge F.
- Back-to-back: minimum 4 cycles per transfer (ISSUE, WAIT_LOW, WAIT_HIGH, RESP) plus 1 IDLE cycle.
- Timeout: rsp_valid with rsp_timeout=1 appears TIMEOUT+1 cycles after ISSUE if mready never completes the low/high sequence.
- All outputs registered; no combinational path from mready to mwvalid.

## Test plan
- Reset: hold rst 3 cycles mid-burst → all outputs 0, cmd_ready=1, busy=0, no rsp_valid.
- Write then read: push write 0x0ABC/0x55, then read 0x0ABC; bus model returns mrdata=0x55 → one mwvalid pulse each, maddr/wen/mwdata correct (mwdata=0 on read), rsp #1 {wen=1,rdata=0}, rsp #2 {wen=0,rdata=0x55}, timeout=0.
- FIFO full: push 5 commands with mready held low → cmd_ready drops after 4 accepted, 5th held off; release mready → all 4 issue in order, 5th accepted once a slot frees.
- Issue stall: queue command with mready=0 in IDLE → no mwvalid until mready=1.
- Timeout: bus model never drops mready after mwvalid → rsp_valid at ISSUE+TIMEOUT+1, rsp_timeout=1, rsp_rdata=0; next command issues normally.
- Simultaneous push/pop: push on the same edge as IDLE pops last entry → count stays 1, second command issues after first response.

Source files
------------

// File: rtl/bus_cmd_issuer.sv
// bus_cmd_issuer
//   Master-side command driver for the dual-bus system. Commands arrive on a
//   valid/ready port and are buffered in a small FIFO. They are issued one at
//   a time on the master port as a one-cycle mwvalid pulse. Each transfer is
//   tracked until mready goes low and then high again, or until a timeout.
//   Completion is reported as a one-cycle response.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake (ready = FIFO not full)
//   cmd_addr/cmd_wdata/cmd_wen      command payload
//   maddr/mwdata/wen                bus address / write data / write enable
//   mwvalid                         one-cycle transfer-start pulse
//   mready                          bus idle (1) / busy (0)
//   mrdata                          bus read data, sampled when mready returns
//   rsp_valid                       one-cycle completion pulse
//   rsp_rdata/rsp_wen/rsp_timeout   completion payload
//   busy                            FIFO non-empty or transfer in flight
module bus_cmd_issuer #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic                  cmd_wen,
  output logic [ADDR_WIDTH-1:0] maddr,
  output logic [DATA_WIDTH-1:0] mwdata,
  output logic                  wen,
  output logic                  mwvalid,
  input  logic                  mready,
  input  logic [DATA_WIDTH-1:0] mrdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_wen,
  output logic                  rsp_timeout,
  output logic                  busy
);

  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned EW   = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);

  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH,
    RESP
  } state_t;

  state_t state;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CNTW-1:0]       count;
  logic [TW-1:0]         tcnt;
  logic                  push;
  logic                  pop;
  logic [EW-1:0]         head;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic                  h_wen;

  assign cmd_ready = (count != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  // Pop only when the bus is idle, so a command is never issued into a busy bus.
  assign pop       = (state == IDLE) && (count != '0) && mready;
  assign head      = mem[rd_ptr];
  assign {h_addr, h_wdata, h_wen} = head;
  assign busy      = (count != '0) || (state != IDLE);

  // FIFO storage has no reset; occupancy is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_addr, cmd_wdata, cmd_wen};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // tcnt counts WAIT_LOW/WAIT_HIGH cycles from zero. The transfer is abandoned
  // on the cycle where the count would reach TIMEOUT. As a result, the response
  // lands TIMEOUT+1 cycles after ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      maddr       <= '0;
      mwdata      <= '0;
      wen         <= 1'b0;
      mwvalid     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_wen     <= 1'b0;
      rsp_timeout <= 1'b0;
      tcnt        <= '0;
    end else begin
      mwvalid   <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            maddr   <= h_addr;
            wen     <= h_wen;
            mwdata  <= h_wen ? h_wdata : '0;
            mwvalid <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (tcnt == TO_LAST) begin
            rsp_valid   <= 1'b1;
            rsp_wen     <= wen;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end else begin
            tcnt <= tcnt + TW'(1);
            if (!mready) begin
              state <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (mready) begin
            rsp_valid   <= 1'b1;
            rsp_wen     <= wen;
            rsp_rdata   <= wen ? '0 : mrdata;
            rsp_timeout <= 1'b0;
            state       <= RESP;
          end else if (tcnt == TO_LAST) begin
            rsp_valid   <= 1'b1;
            rsp_wen     <= wen;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cmd_issuer.sv
// Testbench for bus_cmd_issuer.
//
// Each accepted command has its expected issue fields and response pushed
// into queues. A monitor pops and checks those entries when mwvalid or
// rsp_valid appears. A bus slave model emulates the dual bus. It can
// complete a transfer after d cycles, never drop mready, or drop mready and
// never raise it.
module tb_bus_cmd_issuer;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_wen;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwdata;
  logic          wen;
  logic          mwvalid;
  logic          mready;
  logic [DW-1:0] mrdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_wen;
  logic          rsp_timeout;
  logic          busy;

  logic slave_rdy;
  logic hold_low;
  assign mready = slave_rdy && !hold_low;

  always #5 clk = ~clk;

  bus_cmd_issuer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wen    (cmd_wen),
    .maddr      (maddr),
    .mwdata     (mwdata),
    .wen        (wen),
    .mwvalid    (mwvalid),
    .mready     (mready),
    .mrdata     (mrdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_wen    (rsp_wen),
    .rsp_timeout(rsp_timeout),
    .busy       (busy)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
  } issue_t;

  typedef struct {
    logic          wen;
    logic [DW-1:0] rdata;
    logic          timeout;
    int unsigned   lat;
  } rsp_t;

  // mode 0: complete after d cycles; 1: never drop mready; 2: drop, never raise
  typedef struct {
    int unsigned mode;
    int unsigned d;
  } plan_t;

  issue_t iss_q[$];
  rsp_t   rsp_q[$];
  plan_t  plan_q[$];

  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] bus_mem [logic [AW-1:0]];

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int unsigned cyc    = 0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic logic [DW-1:0] bus_rd(input logic [AW-1:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : '0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  issue_t      cur;
  int unsigned iss_cyc = 0;

  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        check("rsp_in_reset", {31'd0, rsp_valid}, 32'd0);
      end else begin
        if (mwvalid) begin
          if (iss_q.size() == 0) begin
            check("unexpected_issue", {31'd0, mwvalid}, 32'd0);
          end else begin
            cur = iss_q.pop_front();
            check("maddr", {16'd0, maddr}, {16'd0, cur.addr});
            check("wen", {31'd0, wen}, {31'd0, cur.wen});
            check("mwdata", {24'd0, mwdata}, {24'd0, cur.wdata});
            iss_cyc = cyc;
          end
        end
        if (rsp_valid) begin
          if (rsp_q.size() == 0) begin
            check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
          end else begin
            e = rsp_q.pop_front();
            check("rsp_wen", {31'd0, rsp_wen}, {31'd0, e.wen});
            check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
            check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.timeout});
            check("rsp_latency", cyc - iss_cyc, e.lat);
            check("maddr_held", {16'd0, maddr}, {16'd0, cur.addr});
            check("mwdata_held", {24'd0, mwdata}, {24'd0, cur.wdata});
          end
        end
      end
    end
  end

  // ---------------- bus slave model ----------------
  initial begin
    int unsigned   sst;
    int unsigned   left;
    plan_t         p;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_wen;
    logic          raised;
    sst = 0;
    left = 0;
    slave_rdy = 1'b1;
    mrdata = '0;
    forever begin
      @(negedge clk);
      raised = 1'b0;
      if (rst) begin
        sst = 0;
        slave_rdy = 1'b1;
      end else begin
        case (sst)
          0: if (mwvalid && plan_q.size() != 0) begin
               p = plan_q.pop_front();
               s_addr = maddr;
               s_wen = wen;
               s_wdata = mwdata;
               if (p.mode == 1) begin
                 sst = 3;
               end else if (p.mode == 2) begin
                 slave_rdy = 1'b0;
                 sst = 2;
               end else begin
                 slave_rdy = 1'b0;
                 left = p.d;
                 sst = 1;
               end
             end
          1: begin
               left--;
               if (left == 0) begin
                 if (s_wen) bus_mem[s_addr] = s_wdata;
                 else begin
                   mrdata = bus_rd(s_addr);
                   raised = 1'b1;
                 end
                 slave_rdy = 1'b1;
                 sst = 0;
               end
             end
          default: if (rsp_valid) begin
               slave_rdy = 1'b1;
               sst = 0;
             end
        endcase
      end
      if (!raised) mrdata = DW'($urandom);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic w,
                      input int unsigned mode, input int unsigned d);
    int unsigned n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_wen   = w;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", {31'd0, cmd_ready}, 32'd1);
    end else begin
      iss_q.push_back('{addr: a, wen: w, wdata: (w ? wd : '0)});
      plan_q.push_back('{mode: mode, d: d});
      if (mode != 0) begin
        rsp_q.push_back('{wen: w, rdata: '0, timeout: 1'b1, lat: TO + 1});
      end else if (w) begin
        ref_mem[a] = wd;
        rsp_q.push_back('{wen: 1'b1, rdata: '0, timeout: 1'b0, lat: d + 1});
      end else begin
        rsp_q.push_back('{wen: 1'b0, rdata: ref_rd(a), timeout: 1'b0, lat: d + 1});
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((busy || rsp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", {31'd0, (busy || rsp_q.size() != 0)}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic          seen;
    logic [AW-1:0] addrs [4];
    logic [AW-1:0] a;
    int unsigned   mode;
    addrs[0] = 16'h0ABC;
    addrs[1] = 16'h1234;
    addrs[2] = 16'hFFFF;
    addrs[3] = 16'h0000;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    cmd_wen = 1'b0;
    hold_low = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset mid-burst: three reads queued, first one in flight.
    send(16'h0100, 8'h00, 1'b0, 0, 10);
    send(16'h0101, 8'h00, 1'b0, 0, 10);
    send(16'h0102, 8'h00, 1'b0, 0, 10);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    iss_q.delete();
    rsp_q.delete();
    plan_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_maddr", {16'd0, maddr}, 32'd0);
    check("rst_mwdata", {24'd0, mwdata}, 32'd0);
    check("rst_wen", {31'd0, wen}, 32'd0);
    check("rst_mwvalid", {31'd0, mwvalid}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    check("rst_rsp_wen", {31'd0, rsp_wen}, 32'd0);
    check("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | rsp_valid | mwvalid;
    end
    check("post_rst_quiet", {31'd0, seen}, 32'd0);

    // Write then read back, with issue latency from an empty FIFO.
    send(16'h0ABC, 8'h55, 1'b1, 0, 2);
    @(negedge clk);
    check("issue_latency", {31'd0, mwvalid}, 32'd1);
    send(16'h0ABC, 8'hA7, 1'b0, 0, 3);
    drain();

    // FIFO full: four accepted with the bus held busy, fifth held off.
    hold_low = 1'b1;
    send(16'h0200, 8'h11, 1'b1, 0, 2);
    send(16'h0201, 8'h22, 1'b1, 0, 3);
    send(16'h0200, 8'h00, 1'b0, 0, 4);
    send(16'h0201, 8'h00, 1'b0, 0, 2);
    check("full_ready_low", {31'd0, cmd_ready}, 32'd0);
    check("full_busy", {31'd0, busy}, 32'd1);
    fork
      send(16'h0202, 8'h33, 1'b1, 0, 2);
      begin
        seen = 1'b0;
        repeat (4) begin
          @(negedge clk);
          seen = seen | cmd_ready | mwvalid;
        end
        check("full_held_off", {31'd0, seen}, 32'd0);
        hold_low = 1'b0;
      end
    join
    drain();

    // Issue stall while mready is low in IDLE.
    hold_low = 1'b1;
    send(16'h0300, 8'h44, 1'b1, 0, 2);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | mwvalid;
    end
    check("stall_no_issue", {31'd0, seen}, 32'd0);
    hold_low = 1'b0;
    @(negedge clk);
    check("stall_release_issue", {31'd0, mwvalid}, 32'd1);
    drain();

    // Timeouts: never drops mready, then drops and never raises, then normal.
    send(16'h0ABC, 8'h00, 1'b0, 1, 0);
    send(16'h0400, 8'h99, 1'b1, 2, 0);
    send(16'h0400, 8'h00, 1'b0, 0, 2);
    send(16'h0ABC, 8'h00, 1'b0, 0, 5);
    drain();

    // Push on the same edge that pops the only queued entry.
    hold_low = 1'b1;
    send(16'h0500, 8'h66, 1'b1, 0, 2);
    hold_low = 1'b0;
    send(16'h0500, 8'h00, 1'b0, 0, 3);
    check("pushpop_busy", {31'd0, busy}, 32'd1);
    check("pushpop_ready", {31'd0, cmd_ready}, 32'd1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : addrs[$urandom_range(0, 3)];
      mode = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      send(a, DW'($urandom), 1'($urandom), mode, $urandom_range(2, 8));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    check("issues_left", iss_q.size(), 32'd0);
    check("rsps_left", rsp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
